// File: rtl/fifo_wr_arbiter_pkg.sv
// Shared types and helpers for the round-robin FIFO write arbiter.
// Optional build macro used by the arbiter: FIFO_ARB_STATS_EN.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } arb_state_t;

    // Widest request vector the rotating search supports.
    localparam int unsigned RR_MAX = 32;

    // Index of the first set bit of req at or after ptr, wrapping at n.
    // Returns 0 when no bit is set.
    function automatic int unsigned rr_first(
        input logic [RR_MAX-1:0] req,
        input int unsigned       ptr,
        input int unsigned       n
    );
        int unsigned idx;
        logic        found;
        rr_first = 0;
        found    = 1'b0;
        for (int unsigned k = 0; k < RR_MAX; k++) begin
            idx = ptr + k;
            if (idx >= n) begin
                idx = idx - n;
            end
            if ((k < n) && !found && req[idx]) begin
                rr_first = idx;
                found    = 1'b1;
            end
        end
    endfunction

endpackage

// File: rtl/fifo_wr_arbiter_if.sv
// Producer/FIFO-side bundle of the write arbiter: request words, grants, and the FIFO write port.
interface fifo_wr_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned WIDTH   = 16
);

    logic [NUM_REQ-1:0]       req;
    logic [NUM_REQ*WIDTH-1:0] req_data;
    logic [NUM_REQ-1:0]       gnt;
    logic [NUM_REQ-1:0]       ack;
    logic                     fifo_wr_en;
    logic [WIDTH-1:0]         fifo_data_in;
    logic                     fifo_full;

    // Environment side: producers and the FIFO full flag.
    modport master (
        output req,
        output req_data,
        output fifo_full,
        input  gnt,
        input  ack,
        input  fifo_wr_en,
        input  fifo_data_in
    );

    // Arbiter side.
    modport slave (
        input  req,
        input  req_data,
        input  fifo_full,
        output gnt,
        output ack,
        output fifo_wr_en,
        output fifo_data_in
    );

endinterface

// File: rtl/fifo_wr_arbiter_rr_pick.sv
// Combinational rotating-priority encoder: first active requester at or after rr_ptr.
module fifo_arb_rr_pick
    import fifo_arb_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned PW      = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [PW-1:0]      rr_ptr,
    output logic [PW-1:0]      idx,
    output logic               any
);

    always_comb begin
        idx = PW'(rr_first(RR_MAX'(req), 32'(rr_ptr), NUM_REQ));
        any = |req;
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing one FIFO write port among NUM_REQ producers in bursts of up to MAX_BURST.
// Define FIFO_ARB_STATS_EN to add the saturating stall_cnt output.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned WIDTH     = 16,
    parameter int unsigned MAX_BURST = 4
) (
    input  logic              clk,
    input  logic              rst_n,
    fifo_wr_arbiter_if.slave  bus
`ifdef FIFO_ARB_STATS_EN
    ,
    output logic [15:0]       stall_cnt
`endif
);

    localparam int unsigned PW = $clog2(NUM_REQ);
    localparam int unsigned BW = $clog2(MAX_BURST + 1);

    arb_state_t         st, st_nxt;
    logic [PW-1:0]      sel, sel_nxt;
    logic [PW-1:0]      rr_ptr, rr_ptr_nxt;
    logic [BW-1:0]      burst_cnt, burst_nxt;
    logic [NUM_REQ-1:0] gnt_q, gnt_nxt;

    logic [PW-1:0]      pick_idx;
    logic               pick_any;
    logic               req_sel;
    logic               wr_en;
    logic               last_beat;

    fifo_arb_rr_pick #(
        .NUM_REQ (NUM_REQ)
    ) u_pick (
        .req    (bus.req),
        .rr_ptr (rr_ptr),
        .idx    (pick_idx),
        .any    (pick_any)
    );

    // Back-pressure freezes the grant: no write, no burst progress, no release.
    always_comb begin
        req_sel   = bus.req[sel];
        wr_en     = (st == GRANT) && req_sel && !bus.fifo_full;
        last_beat = wr_en && (burst_cnt == BW'(MAX_BURST - 1));
    end

    always_comb begin
        st_nxt     = st;
        sel_nxt    = sel;
        rr_ptr_nxt = rr_ptr;
        burst_nxt  = burst_cnt;
        gnt_nxt    = gnt_q;
        case (st)
            IDLE: begin
                if (pick_any) begin
                    sel_nxt   = pick_idx;
                    gnt_nxt   = NUM_REQ'(1) << pick_idx;
                    burst_nxt = '0;
                    st_nxt    = GRANT;
                end
            end
            GRANT: begin
                if (wr_en) begin
                    burst_nxt = burst_cnt + 1'b1;
                end
                if (last_beat || !req_sel) begin
                    gnt_nxt    = '0;
                    rr_ptr_nxt = (sel == PW'(NUM_REQ - 1)) ? '0 : sel + 1'b1;
                    st_nxt     = IDLE;
                end
            end
            default: begin
                st_nxt  = IDLE;
                gnt_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= IDLE;
            sel       <= '0;
            rr_ptr    <= '0;
            burst_cnt <= '0;
            gnt_q     <= '0;
        end else begin
            st        <= st_nxt;
            sel       <= sel_nxt;
            rr_ptr    <= rr_ptr_nxt;
            burst_cnt <= burst_nxt;
            gnt_q     <= gnt_nxt;
        end
    end

    // Data is forced to zero outside GRANT so reset drives every output low.
    assign bus.gnt          = gnt_q;
    assign bus.ack          = gnt_q & {NUM_REQ{wr_en}};
    assign bus.fifo_wr_en   = wr_en;
    assign bus.fifo_data_in = (st == GRANT) ? bus.req_data[sel*WIDTH +: WIDTH] : '0;

`ifdef FIFO_ARB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stall_cnt <= '0;
        end else if ((st == GRANT) && req_sel && bus.fifo_full && (stall_cnt != '1)) begin
            stall_cnt <= stall_cnt + 1'b1;
        end
    end
`endif

endmodule
